// File: rtl/inv_sbox_layer_iter.sv
// Iterative inverse Ascon S-box layer: inverts COLS_PER_CYCLE columns per RUN cycle, LSB columns first.
// Optional INV_SBOX_SELFCHECK_EN re-applies the forward S-box to each inverted column and flags any disagreement.
module inv_sbox_layer_iter #(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [319:0] state_o,
  output logic         mismatch_o
);

  localparam int N  = 64 / COLS_PER_CYCLE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4 &&
        COLS_PER_CYCLE != 8 && COLS_PER_CYCLE != 16 && COLS_PER_CYCLE != 32 &&
        COLS_PER_CYCLE != 64) begin : g_bad_cols
      $error("inv_sbox_layer_iter: COLS_PER_CYCLE must be a power of two from 1 to 64");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [319:0]    r_work;
  logic [319:0]    w_next;

  function automatic logic [4:0] inv_sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'h00: r = 5'h14; 5'h01: r = 5'h1A; 5'h02: r = 5'h07; 5'h03: r = 5'h0D;
      5'h04: r = 5'h00; 5'h05: r = 5'h09; 5'h06: r = 5'h0E; 5'h07: r = 5'h12;
      5'h08: r = 5'h0A; 5'h09: r = 5'h06; 5'h0A: r = 5'h1D; 5'h0B: r = 5'h01;
      5'h0C: r = 5'h19; 5'h0D: r = 5'h15; 5'h0E: r = 5'h13; 5'h0F: r = 5'h1E;
      5'h10: r = 5'h18; 5'h11: r = 5'h16; 5'h12: r = 5'h0B; 5'h13: r = 5'h11;
      5'h14: r = 5'h03; 5'h15: r = 5'h05; 5'h16: r = 5'h1C; 5'h17: r = 5'h1F;
      5'h18: r = 5'h17; 5'h19: r = 5'h1B; 5'h1A: r = 5'h04; 5'h1B: r = 5'h08;
      5'h1C: r = 5'h0F; 5'h1D: r = 5'h0C; 5'h1E: r = 5'h10; default: r = 5'h02;
    endcase
    return r;
  endfunction

  // Column j belongs to slice j / COLS_PER_CYCLE; only the slice selected by r_k is rewritten.
  always_comb begin
    logic [4:0] w_col;
    logic [4:0] w_inv;
    w_next = r_work;
    for (int j = 0; j < 64; j++) begin
      w_col = {r_work[256+j], r_work[192+j], r_work[128+j], r_work[64+j], r_work[j]};
      w_inv = inv_sbox(w_col);
      if (r_k == KW'(j / COLS_PER_CYCLE)) begin
        w_next[256+j] = w_inv[4];
        w_next[192+j] = w_inv[3];
        w_next[128+j] = w_inv[2];
        w_next[64+j]  = w_inv[1];
        w_next[j]     = w_inv[0];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_work  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_work  <= state_i;
            r_k     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_next;
          if (r_k == KW'(N - 1)) begin
            r_k     <= '0;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);
  assign state_o = r_work;

`ifdef INV_SBOX_SELFCHECK_EN
  logic [319:0] r_shadow;
  logic         r_mismatch;
  logic         w_bad;

  function automatic logic [4:0] fwd_sbox(input logic [4:0] v);
    logic [4:0] r;
    case (v)
      5'h00: r = 5'h04; 5'h01: r = 5'h0B; 5'h02: r = 5'h1F; 5'h03: r = 5'h14;
      5'h04: r = 5'h1A; 5'h05: r = 5'h15; 5'h06: r = 5'h09; 5'h07: r = 5'h02;
      5'h08: r = 5'h1B; 5'h09: r = 5'h05; 5'h0A: r = 5'h08; 5'h0B: r = 5'h12;
      5'h0C: r = 5'h1D; 5'h0D: r = 5'h03; 5'h0E: r = 5'h06; 5'h0F: r = 5'h1C;
      5'h10: r = 5'h1E; 5'h11: r = 5'h13; 5'h12: r = 5'h07; 5'h13: r = 5'h0E;
      5'h14: r = 5'h00; 5'h15: r = 5'h0D; 5'h16: r = 5'h11; 5'h17: r = 5'h18;
      5'h18: r = 5'h10; 5'h19: r = 5'h0C; 5'h1A: r = 5'h01; 5'h1B: r = 5'h19;
      5'h1C: r = 5'h16; 5'h1D: r = 5'h0A; 5'h1E: r = 5'h0F; default: r = 5'h17;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [4:0] w_new;
    logic [4:0] w_orig;
    w_bad = 1'b0;
    for (int j = 0; j < 64; j++) begin
      w_new  = {w_next[256+j], w_next[192+j], w_next[128+j], w_next[64+j], w_next[j]};
      w_orig = {r_shadow[256+j], r_shadow[192+j], r_shadow[128+j], r_shadow[64+j], r_shadow[j]};
      if (r_k == KW'(j / COLS_PER_CYCLE) && fwd_sbox(w_new) != w_orig) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_shadow   <= '0;
      r_mismatch <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start_i) r_shadow <= state_i;
      if (r_state == S_RUN && w_bad)    r_mismatch <= 1'b1;
    end
  end

  assign mismatch_o = r_mismatch;
`else
  assign mismatch_o = 1'b0;
`endif

endmodule
